// File: rtl/branch_redirect_ctrl_pkg.sv
// branch_redirect_ctrl_pkg: FSM state encodings and PC alignment helper for the EX->IF redirect sequencer.
package branch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        BRC_IDLE  = 2'd0,
        BRC_REDIR = 2'd1,
        BRC_FLUSH = 2'd2
    } brc_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_perf_cnt.sv
// perf_cnt: wrapping event counter with asynchronous active-low clear.
module perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (inc_i)
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: turns a taken EX branch into an IF redirect handshake, squashes the
// wrong path until the redirect lands, and counts branches and taken branches.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rstn,
    input  logic             ex_valid,
    input  logic             ex_allowout,
    input  logic             ex_is_br,
    input  logic             ex_jump_taken,
    input  logic [31:0]      ex_target,
    input  logic             if_ready,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    output logic             redir_ade,
    output logic             flush_ifid,
    output logic             ex_kill,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int            CW       = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES > 0 ? FLUSH_CYCLES - 1 : 0);

    brc_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          redir_valid_q;
    logic          redir_ade_q;
    logic [31:0]   redir_pc_q;
    logic          idle;
    logic          retire;
    logic          fire;

    assign idle   = state_q == BRC_IDLE;
    assign retire = ex_valid & ex_allowout & ex_is_br & idle;
    assign fire   = retire & ex_jump_taken;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q       <= BRC_IDLE;
            cnt_q         <= '0;
            redir_valid_q <= 1'b0;
            redir_ade_q   <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            case (state_q)
                BRC_IDLE:
                    if (fire) begin
                        state_q       <= BRC_REDIR;
                        redir_valid_q <= 1'b1;
                        redir_pc_q    <= align_pc(ex_target);
                        redir_ade_q   <= |ex_target[1:0];
                    end
                BRC_REDIR:
                    if (redir_valid_q & if_ready) begin
                        redir_valid_q <= 1'b0;
                        cnt_q         <= CNT_INIT;
                        state_q       <= (FLUSH_CYCLES == 0) ? BRC_IDLE : BRC_FLUSH;
                    end
                BRC_FLUSH:
                    if (cnt_q == '0)
                        state_q <= BRC_IDLE;
                    else
                        cnt_q <= cnt_q - CW'(1);
                default:
                    state_q <= BRC_IDLE;
            endcase
        end
    end

    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign redir_ade   = redir_ade_q;
    // Anything reaching EX outside IDLE is on the wrong path.
    assign flush_ifid  = fire | ~idle;
    assign ex_kill     = ~idle;

    perf_cnt #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (cpu_clk),
        .rst_n (cpu_rstn),
        .inc_i (retire),
        .cnt_o (br_cnt)
    );

    perf_cnt #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (cpu_clk),
        .rst_n (cpu_rstn),
        .inc_i (fire),
        .cnt_o (taken_cnt)
    );

endmodule
